mult_arbiter: RTL and testbench



---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_core.sv | 37 +++
 rtl/mult_arbiter.sv | 104 ++++++++++
 tb/tb_mult_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier arbiter slice.
// Holds the sequencer state encoding and the product type.
package mult_pkg;

  localparam int W_DEF    = 3;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [2*W_DEF-1:0] prod_t;

endpackage

// File: rtl/mult_core.sv
// Shift-add multiplier datapath: A/B/P registers.
// Load captures operands; each step retires one multiplier bit.
module mult_core #(
  parameter int W = mult_pkg::W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mr,
  input  logic [W-1:0]   md,
  output logic [2*W-1:0] p,
  output logic           z
);

  logic [2*W-1:0] a;
  logic [W-1:0]   b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      p <= '0;
    end else if (load) begin
      a <= {{W{1'b0}}, md};
      b <= mr;
      p <= '0;
    end else if (step) begin
      if (b[0]) p <= p + a;
      a <= a << 1;
      b <= b >> 1;
    end
  end

  assign z = (b == '0);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier
// between NREQ requesters; one-cycle ack per result.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] mr,
  input  logic [NREQ*W-1:0] md,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [2*W-1:0]    product,
  output logic [IW-1:0]     done_id,
  output logic              busy
);

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  win_c;
  logic [IW-1:0]  ptr_nxt;
  logic [NREQ-1:0] one;
  logic [2*W-1:0] p;
  logic           z;
  logic           load;
  logic           step;

  function automatic logic [IW-1:0] pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   ptr
  );
    logic [IW-1:0] w;
    logic          f;
    int            idx;
    w = '0;
    f = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!f && r[idx]) begin
        w = IW'(idx);
        f = 1'b1;
      end
    end
    return w;
  endfunction

  assign one     = {{(NREQ-1){1'b0}}, 1'b1};
  assign win_c   = pick(req, rr_ptr);
  assign ptr_nxt = (done_id == IW'(NREQ-1)) ? '0 : done_id + 1'b1;
  assign load    = (state == IDLE) && (|req);
  assign step    = (state == RUN) && !z;
  assign busy    = (state != IDLE);

  mult_core #(.W(W)) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .step (step),
    .mr   (mr[win_c*W +: W]),
    .md   (md[win_c*W +: W]),
    .p    (p),
    .z    (z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      product <= '0;
      done_id <= '0;
      rr_ptr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= one << win_c;
            done_id <= win_c;
            state   <= RUN;
          end
        end
        RUN: begin
          if (z) begin
            ack     <= gnt;
            product <= p;
            state   <= DONE;
          end
        end
        DONE: begin
          ack    <= '0;
          gnt    <= '0;
          rr_ptr <= ptr_nxt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized check of mult_arbiter against a transaction-level
// model: winner, product and ack time per granted request.
module tb_mult_arbiter;
  import mult_pkg::*;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*W-1:0]    mr;
  logic [N*W-1:0]    md;
  logic [N-1:0]      gnt;
  logic [N-1:0]      ack;
  logic [2*W-1:0]    product;
  logic [IW-1:0]     done_id;
  logic              busy;

  int total = 0;
  int bad   = 0;

  // model: time-stamped transaction, not a state machine
  int    cyc;
  bit    m_busy;
  int    m_id;
  int    m_ptr;
  int    m_ack_cyc;
  int    m_prod;
  int    m_last;
  int    obs[$];

  mult_arbiter #(.NREQ(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .mr     (mr),
    .md     (md),
    .gnt    (gnt),
    .ack    (ack),
    .product(product),
    .done_id(done_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int m);
    int l;
    l = 2;
    for (int b = 0; b < W; b++)
      if ((m >> b) & 1) l = b + 3;
    return l;
  endfunction

  function automatic int opnd(input logic [N*W-1:0] v,
                              input int i);
    return int'((v >> (i*W)) & ((1 << W) - 1));
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_id   = 0;
    m_ptr  = 0;
    m_last = 0;
  endtask

  // check this cycle's outputs, advance model, clock once
  task automatic step_cycle();
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    int w;
    eg = m_busy ? N'(1 << m_id) : '0;
    ea = (m_busy && cyc == m_ack_cyc) ? eg : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ack", 32'(ack), 32'(ea));
    chk("done_id", 32'(done_id), m_id);
    if (ea != 0) begin
      m_last = m_prod;
      obs.push_back(int'(done_id));
    end
    chk("product", 32'(product), m_last);
    if (m_busy && cyc == m_ack_cyc) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % N;
    end else if (!m_busy && req != 0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_id      = w;
      m_prod    = opnd(mr, w) * opnd(md, w);
      m_ack_cyc = cyc + lat_of(opnd(mr, w));
      m_busy    = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_prod", 32'(product), 0);
    chk("rst_id", 32'(done_id), 0);
    chk("rst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    mr[i*W +: W] = W'(a);
    md[i*W +: W] = W'(b);
  endtask

  // run one transaction on requester i until the model goes idle
  task automatic one_op(input int i, input int a, input int b);
    int n;
    req = N'(1 << i);
    set_op(i, a, b);
    n = 0;
    step_cycle();
    while (m_busy && n < 10) begin
      if (m_ack_cyc == cyc) req = '0;
      step_cycle();
      n++;
    end
    chk("op_bound", 32'(m_busy), 0);
    req = '0;
  endtask

  initial begin
    int exp_ord[5];
    cyc   = 0;
    rst_n = 1'b1;
    req   = '0;
    mr    = '0;
    md    = '0;
    model_reset();
    #1;
    do_reset();

    // single requester and explicit latency/result check
    req = 4'b0001;
    set_op(0, 5, 6);
    obs.delete();
    for (int c = 0; c < 6; c++) begin
      if (c == 1) chk("s_gnt1", 32'(gnt), 1);
      if (c == 5) begin
        chk("s_ack5", 32'(ack), 1);
        chk("s_p30", 32'(product), 30);
      end
      step_cycle();
    end
    req = '0;
    step_cycle();
    step_cycle();

    // zero operands on requester 2
    one_op(2, 0, 7);
    one_op(2, 7, 0);
    one_op(1, 7, 7);
    chk("p49", 32'(m_last), 49);

    // all operand pairs on random requesters
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        one_op(int'($urandom_range(0, N-1)), a, b);

    // fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 3, 7 - i);
    req = 4'b1111;
    obs.delete();
    for (int c = 0; c < 28; c++) step_cycle();
    req = '0;
    for (int c = 0; c < 8; c++) step_cycle();
    exp_ord = '{0, 1, 2, 3, 0};
    chk("fair_n", 32'(obs.size() >= 5), 1);
    for (int i = 0; i < 5 && i < obs.size(); i++)
      chk("fair_ord", obs[i], exp_ord[i]);

    // operand churn and req drop on requester 1
    req = 4'b0010;
    set_op(1, 6, 5);
    step_cycle();
    for (int c = 0; c < 6; c++) begin
      set_op(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if (c == 2) req = '0;
      step_cycle();
    end
    chk("churn_p", 32'(m_last), 30);
    for (int c = 0; c < 3; c++) step_cycle();

    // reset in the middle of an operation
    req = 4'b1000;
    set_op(3, 7, 3);
    for (int c = 0; c < 3; c++) step_cycle();
    do_reset();
    obs.delete();
    for (int c = 0; c < 8; c++) step_cycle();
    chk("rst_regnt", 32'(obs.size() > 0 ? obs[0] : -1), 3);
    req = '0;
    for (int c = 0; c < 3; c++) step_cycle();

    // random traffic with operand churn
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom);
      mr  = (N*W)'($urandom);
      md  = (N*W)'($urandom);
      step_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
